// File: rtl/uart_tx_arbiter_if.sv
// Bundle between four byte requesters, the arbiter and the UART TX FIFO.
// slave: arbiter side; master: requester/FIFO side that drives the inputs.
interface uart_tx_arbiter_if;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_full;
    logic        wr_en;
    logic [7:0]  d_out;
    logic [3:0]  grant;
    logic        busy;

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, wr_en, d_out, grant, busy
    );

    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, wr_en, d_out, grant, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// 4-way round-robin arbiter that streams requester bytes into a UART TX FIFO.
// Ports: clk, reset (sync, active-high), bus (slave: req_*, tx_full, wr_en, d_out, grant, busy).
module uart_tx_arbiter #(
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned IDLE_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam logic [7:0] MaxB = 8'(MAX_BURST);
    localparam logic [7:0] Tmo  = 8'(IDLE_TIMEOUT);

    typedef enum logic {IDLE, XFER} state_e;

    state_e     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] gsel_q, gsel_d;
    logic [1:0] last_q, last_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] idle_q, idle_d;
    logic [1:0] win, cand;
    logic       win_vld;
    logic       g_valid, g_last;
    logic       xfer, burst_end, timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            gsel_q  <= '0;
            last_q  <= 2'd3;
            byte_q  <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gsel_q  <= gsel_d;
            last_q  <= last_d;
            byte_q  <= byte_d;
            idle_q  <= idle_d;
        end
    end

    // Scan from farthest to nearest so the requester right after
    // last_q overwrites any later candidate.
    always_comb begin
        win_vld = 1'b0;
        win     = 2'd0;
        cand    = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (bus.req_valid[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
    end

    assign g_valid   = bus.req_valid[gsel_q];
    assign g_last    = bus.req_last[gsel_q];
    assign xfer      = (state_q == XFER) && g_valid && !bus.tx_full;
    assign burst_end = xfer && (g_last || (byte_q + 8'd1 == MaxB));
    // A stalled but valid requester clears the counter, so full never times out.
    assign timeout   = !g_valid && (idle_q + 8'd1 == Tmo);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gsel_d  = gsel_q;
        last_d  = last_q;
        byte_d  = byte_q;
        idle_d  = idle_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = XFER;
                    gsel_d  = win;
                    grant_d = 4'b0001 << win;
                    byte_d  = '0;
                    idle_d  = '0;
                end
            end
            XFER: begin
                if (xfer) begin
                    byte_d = byte_q + 8'd1;
                end
                idle_d = g_valid ? 8'd0 : idle_q + 8'd1;
                if (burst_end || timeout) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = gsel_q;
                end
            end
        endcase
    end

    // Outputs are gated by reset so nothing leaks out during the reset cycle.
    always_comb begin
        bus.req_ready = '0;
        bus.wr_en     = 1'b0;
        bus.d_out     = 8'h00;
        bus.busy      = 1'b0;
        if (!reset && state_q == XFER) begin
            bus.busy = 1'b1;
            if (!bus.tx_full) begin
                bus.req_ready = grant_q;
            end
            if (xfer) begin
                bus.wr_en = 1'b1;
                bus.d_out = bus.req_data[{gsel_q, 3'b000} +: 8];
            end
        end
    end

    assign bus.grant = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random traffic
// compared every cycle against a grant-level behavioural model.
module tb_uart_tx_arbiter;
    localparam int MAX_B = 4;
    localparam int TMO   = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0]  vld = '0;
    logic [3:0]  lst = '0;
    logic [31:0] dat = '0;
    logic        full = 1'b0;

    int checks = 0;
    int failures = 0;

    uart_tx_arbiter_if bus ();

    assign bus.req_valid = vld;
    assign bus.req_last  = lst;
    assign bus.req_data  = dat;
    assign bus.tx_full   = full;

    uart_tx_arbiter #(
        .MAX_BURST    (MAX_B),
        .IDLE_TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic setb(input int i, input logic [7:0] v);
        dat[i*8 +: 8] = v;
    endtask

    // Model: owner of the grant (-1 = none), bytes and quiet cycles in
    // this grant, and the last owner for round-robin order.
    bit   mdl_live = 1'b0;
    int   own = -1;
    int   lastg = 3;
    int   bcnt = 0;
    int   icnt = 0;
    int   c;
    logic [3:0] e_grant, e_ready;
    logic       e_wr, e_busy;
    logic [7:0] e_dout;
    logic [3:0] acc_q = '0;
    logic [3:0] prev_vld = '0;
    logic [3:0] prev_grant = '0;
    int   waits [4] = '{0, 0, 0, 0};

    always @(negedge clk) begin
        e_grant = '0;
        e_ready = '0;
        e_wr    = 1'b0;
        e_busy  = 1'b0;
        e_dout  = 8'h00;
        if (own >= 0) begin
            e_grant[own] = 1'b1;
            if (!reset) begin
                e_busy = 1'b1;
                if (!full) begin
                    e_ready[own] = 1'b1;
                    if (vld[own]) begin
                        e_wr   = 1'b1;
                        e_dout = dat[own*8 +: 8];
                    end
                end
            end
        end
        if (mdl_live) begin
            chk("grant", 32'(bus.grant), 32'(e_grant));
            chk("busy", 32'(bus.busy), 32'(e_busy));
            chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
            chk("wr_en", 32'(bus.wr_en), 32'(e_wr));
            chk("d_out", 32'(bus.d_out), 32'(e_dout));
        end
        if (reset) begin
            own = -1;
            lastg = 3;
            bcnt = 0;
            icnt = 0;
            mdl_live = 1'b1;
        end else if (mdl_live) begin
            if (own < 0) begin
                for (int k = 1; k <= 4; k++) begin
                    c = (lastg + k) % 4;
                    if (own < 0 && vld[c]) begin
                        own = c;
                        bcnt = 0;
                        icnt = 0;
                    end
                end
            end else begin
                if (e_wr) bcnt++;
                if (vld[own]) icnt = 0;
                else icnt++;
                if ((e_wr && (lst[own] || bcnt == MAX_B)) || icnt == TMO) begin
                    lastg = own;
                    own = -1;
                end
            end
        end
        // A requester waiting through a grant start must be served within 3.
        if (reset) begin
            for (int i = 0; i < 4; i++) waits[i] = 0;
        end else if (mdl_live && prev_grant == 0 && bus.grant != 0) begin
            for (int i = 0; i < 4; i++) begin
                if (!bus.grant[i] && prev_vld[i]) begin
                    waits[i]++;
                    checks++;
                    if (waits[i] > 3) begin
                        failures++;
                        $display("FAIL fairness req%0d waited=%0d limit=3", i, waits[i]);
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!vld[i] || bus.grant[i]) waits[i] = 0;
        end
        prev_vld = vld;
        prev_grant = bus.grant;
        acc_q = vld & bus.req_ready;
    end

    logic [3:0] g3 [10] = '{0, 4, 4, 4, 4, 0, 8, 0, 4, 0};
    logic       w3 [10] = '{0, 1, 1, 1, 1, 0, 1, 0, 1, 0};
    logic [7:0] d3 [10] = '{8'h00, 8'h20, 8'h21, 8'h22, 8'h23,
                            8'h00, 8'h30, 8'h00, 8'h24, 8'h00};
    logic [3:0] rr [10] = '{0, 4, 0, 8, 0, 1, 0, 2, 0, 4};
    logic [3:0] g5 [13] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 2, 0};
    int sil [4] = '{0, 0, 0, 0};

    initial begin
        int a0, a1, a2, a3;
        logic [3:0] eg;
        logic ew;
        logic [7:0] ed;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        smp();
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_wr", 32'(bus.wr_en), 32'h0);
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_dout", 32'(bus.d_out), 32'h0);
        tick();
        reset = 1'b0;
        smp();
        chk("idle_grant", 32'(bus.grant), 32'h0);

        // Single requester, three bytes
        tick();
        vld = 4'b0010;
        setb(1, 8'hA1);
        smp();
        chk("t1_gap", 32'(bus.grant), 32'h0);
        tick();
        smp();
        chk("t1_grant", 32'(bus.grant), 32'h2);
        chk("t1_d1", 32'(bus.d_out), 32'hA1);
        chk("t1_w1", 32'(bus.wr_en), 32'h1);
        tick();
        setb(1, 8'hA2);
        smp();
        chk("t1_d2", 32'(bus.d_out), 32'hA2);
        tick();
        setb(1, 8'hA3);
        lst[1] = 1'b1;
        smp();
        chk("t1_d3", 32'(bus.d_out), 32'hA3);
        chk("t1_w3", 32'(bus.wr_en), 32'h1);
        tick();
        vld = '0;
        lst = '0;
        smp();
        chk("t1_end", 32'(bus.grant), 32'h0);
        chk("t1_busy", 32'(bus.busy), 32'h0);

        // Round-robin with single-byte messages
        for (int k = 0; k < 10; k++) begin
            tick();
            vld = 4'hF;
            lst = 4'hF;
            smp();
            chk($sformatf("rr_%0d", k), 32'(bus.grant), 32'(rr[k]));
        end
        tick();
        vld = '0;
        lst = '0;
        smp();

        // Burst cap: req 2 streams, req 3 cuts in after MAX_B bytes
        a2 = 0;
        a3 = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            vld[2] = (k <= 8);
            setb(2, 8'(8'h20 + a2));
            lst[2] = (a2 >= 4);
            vld[3] = (k >= 1) && (a3 == 0);
            setb(3, 8'h30);
            lst[3] = 1'b1;
            smp();
            chk($sformatf("cap_g%0d", k), 32'(bus.grant), 32'(g3[k]));
            chk($sformatf("cap_w%0d", k), 32'(bus.wr_en), 32'(w3[k]));
            chk($sformatf("cap_d%0d", k), 32'(bus.d_out), 32'(d3[k]));
            if (bus.req_valid[2] && bus.req_ready[2]) a2++;
            if (bus.req_valid[3] && bus.req_ready[3]) a3++;
        end
        vld = '0;
        lst = '0;

        // Backpressure: FIFO full for 20 cycles mid-burst
        a1 = 0;
        for (int k = 0; k < 26; k++) begin
            tick();
            vld[1] = (a1 < 4);
            setb(1, 8'(8'h10 + a1));
            lst[1] = (a1 == 3);
            full = (k >= 2) && (k <= 21);
            smp();
            eg = (k >= 1 && k <= 24) ? 4'h2 : 4'h0;
            ew = (k == 1) || (k >= 22 && k <= 24);
            ed = (k == 1) ? 8'h10 : (ew ? 8'(8'h10 + k - 21) : 8'h00);
            chk($sformatf("bp_g%0d", k), 32'(bus.grant), 32'(eg));
            chk($sformatf("bp_w%0d", k), 32'(bus.wr_en), 32'(ew));
            chk($sformatf("bp_d%0d", k), 32'(bus.d_out), 32'(ed));
            chk($sformatf("bp_r%0d", k), 32'(bus.req_ready),
                32'(ew ? 4'h2 : 4'h0));
            if (bus.req_valid[1] && bus.req_ready[1]) a1++;
        end
        full = 1'b0;
        vld = '0;
        lst = '0;

        // Idle timeout: req 0 goes quiet after one byte, req 1 waits
        a0 = 0;
        a1 = 0;
        for (int k = 0; k < 13; k++) begin
            tick();
            vld[0] = (a0 == 0);
            setb(0, 8'h40);
            lst[0] = 1'b0;
            vld[1] = (a1 == 0);
            setb(1, 8'h50);
            lst[1] = 1'b1;
            smp();
            ew = (k == 1) || (k == 11);
            ed = (k == 1) ? 8'h40 : ((k == 11) ? 8'h50 : 8'h00);
            chk($sformatf("to_g%0d", k), 32'(bus.grant), 32'(g5[k]));
            chk($sformatf("to_w%0d", k), 32'(bus.wr_en), 32'(ew));
            chk($sformatf("to_d%0d", k), 32'(bus.d_out), 32'(ed));
            if (bus.req_valid[0] && bus.req_ready[0]) a0++;
            if (bus.req_valid[1] && bus.req_ready[1]) a1++;
        end
        vld = '0;
        lst = '0;

        // Reset in the second byte cycle of req 1
        a1 = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            vld[1] = 1'b1;
            setb(1, 8'(8'h60 + a1));
            lst[1] = 1'b0;
            vld[0] = (k >= 3);
            setb(0, 8'h70);
            lst[0] = 1'b1;
            reset = (k == 2);
            smp();
            if (k == 1) begin
                chk("rs_g1", 32'(bus.grant), 32'h2);
                chk("rs_d1", 32'(bus.d_out), 32'h60);
            end
            if (k == 3) begin
                chk("rs_g3", 32'(bus.grant), 32'h0);
                chk("rs_w3", 32'(bus.wr_en), 32'h0);
                chk("rs_b3", 32'(bus.busy), 32'h0);
            end
            if (k == 4) begin
                chk("rs_g4", 32'(bus.grant), 32'h1);
                chk("rs_d4", 32'(bus.d_out), 32'h70);
            end
            if (bus.req_valid[1] && bus.req_ready[1]) a1++;
        end
        tick();
        vld = '0;
        lst = '0;
        reset = 1'b0;
        smp();

        // Random traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            reset = ($urandom_range(0, 599) == 0);
            full = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < 4; i++) begin
                if (acc_q[i] || !vld[i]) begin
                    if (acc_q[i] && $urandom_range(0, 7) == 0)
                        sil[i] = $urandom_range(1, 14);
                    if (sil[i] > 0) begin
                        sil[i]--;
                        vld[i] = 1'b0;
                    end else begin
                        vld[i] = ($urandom_range(0, 9) < 6);
                    end
                    setb(i, 8'($urandom));
                    lst[i] = ($urandom_range(0, 3) == 0);
                end
            end
        end
        tick();
        vld = '0;
        reset = 1'b0;
        full = 1'b0;
        repeat (3) smp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 16, sets the maximum bytes per grant before forced re-arbitration; legal range 1-255.
REQ-002 Parameter IDLE_TIMEOUT, default 8, sets the consecutive cycles without req_valid on the granted requester before the grant is released; legal range 1-255.
REQ-003 clk  input  1  single clock for all sequential logic, rising-edge only.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  4  per-requester byte-valid; bit i belongs to requester i.
REQ-006 req_data  input  32  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 req_last  input  4  per-requester end-of-message marker, qualified by req_valid.
REQ-008 req_ready  output  4  per-requester accept; a byte transfers when req_valid[i] and req_ready[i] are both high.
REQ-009 tx_full  input  1  full flag from the UART transmit FIFO.
REQ-010 wr_en  output  1  write strobe to the UART transmit FIFO.
REQ-011 d_out  output  8  byte to the UART transmit FIFO data input.
REQ-012 grant  output  4  one-hot registered grant; all-zero when no requester holds the grant.
REQ-013 busy  output  1  high while in XFER.

Function
REQ-014 States SHALL be IDLE and XFER only.
REQ-015 IDLE: if any req_valid is high, select the winner round-robin (search starts at last_grant+1, modulo 4), register one-hot grant, clear byte_cnt and idle_cnt, and enter XFER on the next edge; else remain in IDLE with grant = 0.
REQ-016 Arbitration latency SHALL be exactly 1 cycle: req_valid sampled in IDLE at edge N gives grant high after edge N, and the first transfer is possible in that same cycle.
REQ-017 XFER: req_ready[g] = !tx_full for the granted index g (combinational); all other req_ready bits SHALL be 0. All req_ready bits SHALL be 0 in IDLE.
REQ-018 wr_en = req_valid[g] & req_ready[g] and d_out = req_data slice g, both combinational; d_out = 8'h00 when wr_en is low.
REQ-019 wr_en SHALL never assert while tx_full is high.
REQ-020 Each transfer SHALL increment byte_cnt (8-bit).
REQ-021 XFER SHALL exit to IDLE on the edge that ends a transfer with req_last[g] high, or a transfer that makes byte_cnt equal to MAX_BURST; last_grant is updated to g on exit.
REQ-022 idle_cnt (8-bit) SHALL increment on each XFER cycle with req_valid[g] low, clear on any cycle with req_valid[g] high, and force exit to IDLE (last_grant = g) when it reaches IDLE_TIMEOUT.
REQ-023 Cycles with tx_full high and req_valid[g] high SHALL NOT count toward idle_cnt; the stall is held indefinitely.
REQ-024 The exit cycle SHALL be followed by at least one IDLE cycle (1-cycle arbitration gap between grants).
REQ-025 A requester that drops req_valid mid-message without req_last SHALL keep the grant until the timeout or the MAX_BURST limit.
REQ-026 If a requester raises req_valid while another holds the grant, it SHALL wait; a request is never lost, and the waiting requester is served within 3 grants.

Reset
REQ-027 With reset high at a rising edge: state = IDLE, grant = 4'b0000, last_grant = 3 (requester 0 has first priority), byte_cnt = 0, idle_cnt = 0.
REQ-028 During and after reset: wr_en = 0, req_ready = 0, busy = 0, d_out = 8'h00.
REQ-029 Reset mid-XFER SHALL abort the burst immediately; the bytes already written to the FIFO are not retracted.

Verification
REQ-030 Single requester: req 1 sends 3 bytes 8'hA1, 8'hA2, 8'hA3, with last on 8'hA3 -> grant = 4'b0010 one cycle after valid, 3 consecutive wr_en pulses with d_out A1, A2, A3, then IDLE and grant = 0.
REQ-031 Round-robin: all 4 requesters continuously valid, 1-byte messages (last always high) -> grant order 0, 1, 2, 3, 0 ...; each grant is separated by exactly one IDLE cycle.
REQ-032 Burst cap: MAX_BURST = 4, req 2 streams 10 bytes with no last, req 3 also valid -> after 4 bytes, grant moves to req 3; req 2 resumes later with its 5th byte intact.
REQ-033 Backpressure: tx_full held high for 20 cycles mid-burst -> wr_en = 0 and req_ready = 0 throughout, no timeout, the grant is held; the burst completes once tx_full falls.
REQ-034 Timeout: IDLE_TIMEOUT = 8, granted req 0 drops valid after 1 byte -> exit to IDLE after 8 cycles, grant = 0, and req 1 is then granted if valid.
REQ-035 Reset mid-burst: reset asserted in the 2nd byte cycle of req 1 -> wr_en, grant, and busy are 0 the next cycle; the first grant after reset goes to req 0 when reqs 0 and 1 are both valid.
